// File: rtl/computation_pipe.sv
// computation_pipe: two-stage operand-latch / execute pipeline.
// Stage 1 latches an operation. Stage 2 shifts B, muxes the operands, runs
// the ALU, and writes C and the {V,N,Z} status flags. Valid/ready handshakes
// on both sides let the pipe stall behind a slow consumer without losing ops.
module computation_pipe #(
   parameter int WIDTH   = 16,
   parameter int SHIFT_W = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic               asel,
   input  logic               bsel,
   input  logic [1:0]         shift,
   input  logic [SHIFT_W-1:0] shamt,
   input  logic [1:0]         ALUop,
   input  logic               loadc,
   input  logic               loads,
   input  logic [WIDTH-1:0]   A,
   input  logic [WIDTH-1:0]   B,
   input  logic [WIDTH-1:0]   sximm,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [WIDTH-1:0]   C,
   output logic [2:0]         status
);

   typedef enum logic [1:0] {
      SH_NONE = 2'b00,
      SH_LSL  = 2'b01,
      SH_LSR  = 2'b10,
      SH_ASR  = 2'b11
   } shift_e;

   typedef enum logic [1:0] {
      ALU_ADD = 2'b00,
      ALU_SUB = 2'b01,
      ALU_AND = 2'b10,
      ALU_NOT = 2'b11
   } alu_e;

   localparam int MSB = WIDTH - 1;

   // Stage-1 operand registers
   logic               r_s1_valid;
   logic               r_asel;
   logic               r_bsel;
   shift_e             r_shift;
   logic [SHIFT_W-1:0] r_shamt;
   alu_e               r_aluop;
   logic               r_loadc;
   logic               r_loads;
   logic [WIDTH-1:0]   r_a;
   logic [WIDTH-1:0]   r_b;
   logic [WIDTH-1:0]   r_imm;

   // Stage-2 architectural registers
   logic               r_out_valid;
   logic [WIDTH-1:0]   r_c;
   logic [2:0]         r_status;

   // Combinational datapath
   logic               w_s2_load;
   logic               w_accept;
   logic [WIDTH-1:0]   w_shifted;
   logic [WIDTH-1:0]   w_ain;
   logic [WIDTH-1:0]   w_bin;
   logic [WIDTH-1:0]   w_result;
   logic               w_v;
   logic [2:0]         w_flags;

   // Stage 2 can take a new op whenever its current result is absent or
   // is being consumed this cycle. Stage 1 can take one whenever it is
   // empty or is handing its op to stage 2 on the same edge.
   assign w_s2_load = !r_out_valid || out_ready;
   assign in_ready  = !r_s1_valid || w_s2_load;
   assign w_accept  = in_valid && in_ready;

   // Stage 1: latch the operation on accept; empty when stage 2 drains it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         // NOTE: operand registers are reset too, so a discarded op leaves
         // no stale X or old value that could reach C after reset.
         r_s1_valid <= 1'b0;
         r_asel     <= 1'b0;
         r_bsel     <= 1'b0;
         r_shift    <= SH_NONE;
         r_shamt    <= '0;
         r_aluop    <= ALU_ADD;
         r_loadc    <= 1'b0;
         r_loads    <= 1'b0;
         r_a        <= '0;
         r_b        <= '0;
         r_imm      <= '0;
      end else begin
         // NOTE: non-blocking assignments here, so every register samples
         // pre-edge values no matter how the always blocks are ordered.
         if (w_accept) begin
            r_s1_valid <= 1'b1;
            r_asel     <= asel;
            r_bsel     <= bsel;
            r_shift    <= shift_e'(shift);
            r_shamt    <= shamt;
            r_aluop    <= alu_e'(ALUop);
            r_loadc    <= loadc;
            r_loads    <= loads;
            r_a        <= A;
            r_b        <= B;
            r_imm      <= sximm;
         end else if (w_s2_load) begin
            r_s1_valid <= 1'b0;
         end
      end
   end

   // Barrel shifter on the latched B. Verilog shift semantics already give
   // zero for LSL/LSR and full sign fill for ASR when shamt >= WIDTH.
   always_comb begin
      // NOTE: default first, so no path through this block can infer a latch.
      w_shifted = r_b;
      unique case (r_shift)
         SH_NONE: w_shifted = r_b;
         SH_LSL:  w_shifted = r_b << r_shamt;
         SH_LSR:  w_shifted = r_b >> r_shamt;
         SH_ASR:  w_shifted = $unsigned($signed(r_b) >>> r_shamt);
         default: w_shifted = r_b;
      endcase
   end

   // Operand select and ALU with signed-overflow detection.
   always_comb begin
      w_ain    = r_asel ? r_a : '0;
      w_bin    = r_bsel ? r_imm : w_shifted;
      w_result = '0;
      w_v      = 1'b0;
      unique case (r_aluop)
         ALU_ADD: begin
            w_result = w_ain + w_bin;
            w_v      = (w_ain[MSB] == w_bin[MSB]) && (w_result[MSB] != w_ain[MSB]);
         end
         ALU_SUB: begin
            w_result = w_ain - w_bin;
            w_v      = (w_ain[MSB] != w_bin[MSB]) && (w_result[MSB] != w_ain[MSB]);
         end
         ALU_AND: w_result = w_ain & w_bin;
         ALU_NOT: w_result = ~w_bin;
         default: w_result = '0;
      endcase
      w_flags = {w_v, w_result[MSB], (w_result == '0)};
   end

   // Stage 2: execute and write back. The pipe holds while a result is
   // pending and unconsumed; otherwise out_valid follows stage-1 occupancy.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_out_valid <= 1'b0;
         r_c         <= '0;
         r_status    <= 3'b000;
      end else if (w_s2_load) begin
         r_out_valid <= r_s1_valid;
         if (r_s1_valid) begin
            if (r_loadc) r_c      <= w_result;
            if (r_loads) r_status <= w_flags;
         end
      end
   end

   assign out_valid = r_out_valid;
   assign C         = r_c;
   assign status    = r_status;

endmodule

// File: tb/tb_computation_pipe.sv
// Bench for computation_pipe: directed vectors with literal expectations,
// plus an in-order operation model checked on every falling edge.
module tb_computation_pipe;

   localparam int W  = 16;
   localparam int SW = 4;

   logic          clk = 1'b0;
   logic          rst_n = 1'b1;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic          asel = 1'b0;
   logic          bsel = 1'b0;
   logic [1:0]    shift = 2'b00;
   logic [SW-1:0] shamt = '0;
   logic [1:0]    ALUop = 2'b00;
   logic          loadc = 1'b0;
   logic          loads = 1'b0;
   logic [W-1:0]  A = '0;
   logic [W-1:0]  B = '0;
   logic [W-1:0]  sximm = '0;
   logic          out_valid;
   logic          out_ready = 1'b1;
   logic [W-1:0]  C;
   logic [2:0]    status;

   always #5 clk = ~clk;

   computation_pipe #(.WIDTH(W), .SHIFT_W(SW)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .asel(asel), .bsel(bsel), .shift(shift), .shamt(shamt),
      .ALUop(ALUop), .loadc(loadc), .loads(loads),
      .A(A), .B(B), .sximm(sximm),
      .out_valid(out_valid), .out_ready(out_ready),
      .C(C), .status(status)
   );

   int checks   = 0;
   int failures = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   typedef struct {
      logic          asel;
      logic          bsel;
      logic [1:0]    shift;
      logic [SW-1:0] shamt;
      logic [1:0]    aluop;
      logic          loadc;
      logic          loads;
      logic [W-1:0]  a;
      logic [W-1:0]  b;
      logic [W-1:0]  imm;
   } op_t;

   function automatic op_t mk(input logic as, input logic bs, input logic [1:0] sh,
                              input int n, input logic [1:0] op, input logic lc,
                              input logic ls, input int a, input int b, input int imm);
      op_t o;
      o.asel = as; o.bsel = bs; o.shift = sh; o.shamt = SW'(n); o.aluop = op;
      o.loadc = lc; o.loads = ls; o.a = W'(a); o.b = W'(b); o.imm = W'(imm);
      return o;
   endfunction

   // ---------------- reference model (plain arithmetic) ----------------
   function automatic longint to_s(input logic [W-1:0] x);
      return x[W-1] ? longint'(x) - (longint'(1) << W) : longint'(x);
   endfunction

   function automatic logic [W-1:0] model_shift(input op_t o);
      longint bv = longint'(o.b);
      int     n  = int'(o.shamt);
      if (n == 0) return o.b;
      case (o.shift)
         2'b01:   return (n >= W) ? '0 : W'(bv * (longint'(1) << n));
         2'b10:   return (n >= W) ? '0 : W'(bv / (longint'(1) << n));
         2'b11:   return W'(to_s(o.b) >>> n);
         default: return o.b;
      endcase
   endfunction

   function automatic void model_exec(input op_t o, inout logic [W-1:0] mc, inout logic [2:0] ms);
      logic [W-1:0] ain, bin, r;
      longint       full;
      logic         v;
      ain = o.asel ? o.a : '0;
      bin = o.bsel ? o.imm : model_shift(o);
      v   = 1'b0;
      case (o.aluop)
         2'b00: begin full = to_s(ain) + to_s(bin); r = W'(full); end
         2'b01: begin full = to_s(ain) - to_s(bin); r = W'(full); end
         2'b10: begin full = 0; r = ain & bin; end
         default: begin full = 0; r = ~bin; end
      endcase
      if (o.aluop[1] == 1'b0)
         v = (full > ((longint'(1) << (W-1)) - 1)) || (full < -(longint'(1) << (W-1)));
      if (o.loadc) mc = r;
      if (o.loads) ms = {v, r[W-1], (r == '0)};
   endfunction

   op_t          q[$];
   bit           presenting = 1'b0;
   logic [W-1:0] m_c = '0;
   logic [2:0]   m_s = '0;
   int           m_inflight;
   op_t          m_op;

   // Compare process: each new out_valid presentation is the next accepted
   // op in order; C/status must always match the model's architectural view.
   always @(negedge clk) begin
      if (!rst_n) begin
         q.delete();
         presenting = 1'b0;
         m_c = '0;
         m_s = '0;
      end else begin
         if (out_valid && !presenting) begin
            if (q.size() == 0) begin
               check("spurious_completion", 32'(out_valid), 32'd0);
            end else begin
               m_op = q.pop_front();
               model_exec(m_op, m_c, m_s);
               presenting = 1'b1;
            end
         end
         m_inflight = q.size() + (presenting ? 1 : 0);
         check("model_in_ready", 32'(in_ready), 32'((m_inflight < 2) || out_ready));
         check("model_C", 32'(C), 32'(m_c));
         check("model_status", 32'(status), 32'(m_s));
         if (in_valid && in_ready) begin
            m_op.asel = asel; m_op.bsel = bsel; m_op.shift = shift; m_op.shamt = shamt;
            m_op.aluop = ALUop; m_op.loadc = loadc; m_op.loads = loads;
            m_op.a = A; m_op.b = B; m_op.imm = sximm;
            q.push_back(m_op);
         end
         if (out_valid && out_ready) presenting = 1'b0;
      end
   end

   // ---------------- stimulus ----------------
   task automatic drive(input op_t o);
      asel = o.asel; bsel = o.bsel; shift = o.shift; shamt = o.shamt; ALUop = o.aluop;
      loadc = o.loadc; loads = o.loads; A = o.a; B = o.b; sximm = o.imm;
      in_valid = 1'b1;
   endtask

   // Present an op and return #1 after the edge that accepts it.
   task automatic send(input op_t o);
      bit acc = 1'b0;
      drive(o);
      for (int i = 0; i < 50 && !acc; i++) begin
         @(negedge clk);
         acc = in_ready;
         @(posedge clk);
         #1;
      end
      if (!acc) check("send_timeout", 32'd0, 32'd1);
      in_valid = 1'b0;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   int   got[$];
   int   exp3[3] = '{3, 30, 300};
   bit   acc3;

   initial begin
      #2 rst_n = 1'b0;
      #1;
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_C", 32'(C), 32'd0);
      check("rst_status", 32'(status), 32'd0);
      check("rst_in_ready", 32'(in_ready), 32'd1);
      step();
      step();
      rst_n = 1'b1;
      out_ready = 1'b1;

      // 46 + (29 >> 1) = 60, latency: accept edge then result edge
      send(mk(1, 0, 2'b10, 1, 2'b00, 1, 1, 46, 29, 0));
      check("lat_not_yet", 32'(out_valid), 32'd0);
      step();
      check("lat_out_valid", 32'(out_valid), 32'd1);
      check("lsr_add_C", 32'(C), 32'd60);
      check("lsr_add_status", 32'(status), 32'd0);

      // 46 + (29 << 1) = 104
      send(mk(1, 0, 2'b01, 1, 2'b00, 1, 1, 46, 29, 0));
      step();
      check("lsl_add_C", 32'(C), 32'd104);
      check("lsl_add_status", 32'(status), 32'd0);

      // flag-only compare: 5 - 5 sets Z, C holds
      send(mk(1, 0, 2'b00, 0, 2'b01, 0, 1, 5, 5, 0));
      step();
      check("cmp_C_hold", 32'(C), 32'd104);
      check("cmp_status", 32'(status), 32'b001);

      // signed overflow 0x7FFF + 1
      send(mk(1, 0, 2'b00, 0, 2'b00, 1, 1, 16'h7FFF, 1, 0));
      step();
      check("ovf_C", 32'(C), 32'h8000);
      check("ovf_status", 32'(status), 32'b110);

      // 0 + (0x8000 >>> 15) = 0xFFFF
      send(mk(0, 0, 2'b11, 15, 2'b00, 1, 1, 0, 16'h8000, 0));
      step();
      check("asr_C", 32'(C), 32'hFFFF);
      check("asr_status", 32'(status), 32'b010);

      // back-to-back: AND with immediate, then NOT of unshifted B
      send(mk(1, 1, 2'b00, 0, 2'b10, 1, 1, 16'h00FF, 0, 16'h0F0F));
      send(mk(1, 0, 2'b00, 0, 2'b11, 1, 1, 0, 16'hFFFF, 0));
      check("and_C", 32'(C), 32'h000F);
      check("and_status", 32'(status), 32'b000);
      step();
      check("not_C", 32'(C), 32'h0000);
      check("not_status", 32'(status), 32'b001);
      step();
      check("idle_clears_valid", 32'(out_valid), 32'd0);

      // backpressure: two ops fill the pipe, third waits
      out_ready = 1'b0;
      send(mk(1, 0, 2'b00, 0, 2'b00, 1, 1, 1, 2, 0));
      send(mk(1, 0, 2'b00, 0, 2'b00, 1, 1, 10, 20, 0));
      drive(mk(1, 0, 2'b00, 0, 2'b00, 1, 1, 100, 200, 0));
      check("bp_in_ready_low", 32'(in_ready), 32'd0);
      check("bp_head_C", 32'(C), 32'd3);
      step();
      check("bp_hold_ready", 32'(in_ready), 32'd0);
      check("bp_hold_valid", 32'(out_valid), 32'd1);
      check("bp_hold_C", 32'(C), 32'd3);
      out_ready = 1'b1;
      acc3 = 1'b0;
      for (int cyc = 0; cyc < 20 && got.size() < 3; cyc++) begin
         @(negedge clk);
         if (out_valid && out_ready) got.push_back(int'(C));
         if (in_valid && in_ready) acc3 = 1'b1;
         step();
         if (acc3) in_valid = 1'b0;
      end
      in_valid = 1'b0;
      check("bp_count", 32'(got.size()), 32'd3);
      for (int i = 0; i < 3; i++)
         if (got.size() > i) check("bp_order", 32'(got[i]), 32'(exp3[i]));
      step();
      step();

      // reset with an op sitting in stage 1
      send(mk(1, 0, 2'b00, 0, 2'b00, 1, 1, 7, 8, 0));
      rst_n = 1'b0;
      #1;
      check("mid_rst_valid", 32'(out_valid), 32'd0);
      check("mid_rst_C", 32'(C), 32'd0);
      check("mid_rst_status", 32'(status), 32'd0);
      step();
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         check("no_ghost_completion", 32'(out_valid), 32'd0);
      end
      send(mk(1, 0, 2'b00, 0, 2'b00, 1, 1, 2, 3, 0));
      step();
      check("post_rst_valid", 32'(out_valid), 32'd1);
      check("post_rst_C", 32'(C), 32'd5);
      step();
      step();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/computation_pipe.md
Name: computation_pipe

Overview:
Parametrised, two-stage pipelined successor to the single-cycle computation datapath. Selects operands (A or zero, shifted B or sign-extended immediate) and applies a multi-bit barrel shift. Computes ADD/SUB/AND/NOT and writes result register C and status flags Z/N/V under loadc/loads. Uses valid/ready handshakes on both sides so the block can stall behind a busy writeback.

Parameters:
WIDTH, 16, datapath width in bits (>=4)
SHIFT_W, 4, width of shift amount; 2**SHIFT_W >= WIDTH required

Ports:
clk  input  1  clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operation presented
in_ready  output  1  block accepts operation this cycle
asel  input  1  1: Ain=A, 0: Ain=0
bsel  input  1  0: Bin=shifted B, 1: Bin=sximm
shift  input  2  00 none, 01 LSL, 10 LSR, 11 ASR
shamt  input  SHIFT_W  shift distance
ALUop  input  2  00 ADD, 01 SUB (Ain-Bin), 10 AND, 11 NOT Bin
loadc  input  1  write result into C
loads  input  1  write flags into status
A  input  WIDTH  operand A
B  input  WIDTH  operand B (shifter input)
sximm  input  WIDTH  immediate operand
out_valid  output  1  one completed operation pending
out_ready  input  1  consumer takes completion
C  output  WIDTH  result register
status  output  3  {V,N,Z} flag register

Behaviour:
- Reset (rst_n low, async): s1_valid=0, out_valid=0, C=0, status=3'b000, operand regs 0. in_ready follows the equation below, so it is 1 during and after reset.
- Stage 1 (operand latch): captures all inputs when in_valid && in_ready.
- in_ready = !s1_valid || s2_load, where s2_load = !out_valid || out_ready. This is combinational from out_ready; there is no other combinational path.
- Stage 2 (execute/writeback): when s1_valid && s2_load, computes and registers. C is written only if loadc. status is written only if loads. out_valid is set to 1.
- Stage 2 with no new operation: if s2_load && !s1_valid, out_valid is cleared.
- Throughput and latency: 1 op/cycle. Op accepted at edge k updates C/status and raises out_valid at edge k+1 with no stall. Each stall cycle adds one cycle.
- Shifter (applied to B before bsel mux):
  - shamt=0 or shift=00 passes B unchanged.
  - shamt>=WIDTH: LSL/LSR give 0; ASR gives all bits equal to B[WIDTH-1].
  - LSL/LSR fill with 0; ASR fills with the sign bit.
- ALU: all results truncated to WIDTH bits.
  - Z = (result==0).
  - N = result[WIDTH-1].
  - V = signed overflow for ADD/SUB; 0 for AND/NOT.
- loadc=0 / loads=0: the op still completes (out_valid pulses) and the corresponding register holds its old value. Flag-only compare is SUB with loads=1, loadc=0.
- Backpressure: with out_valid=1 and out_ready=0, stage 2 holds. Stage 1 may hold one more op, so at most 2 ops are in flight. Completions are in order; nothing is dropped or duplicated.
- Simultaneous accept and advance in one cycle is legal (full-throughput pipelining).
- Reset mid-operation: in-flight ops are discarded and no completion is reported for them.
- out_valid is the only completion indicator. C and status are architectural registers, stable between writes.

Test Plan:
- A=46, B=29, asel=1, bsel=0, shift=10, shamt=1, ADD, loadc=loads=1 -> C=60, status=000, out_valid 2 edges after accept.
- Same operands, shift=01, shamt=1 -> C=104 (46+58), status=000.
- A=5, B=5, SUB, loadc=0, loads=1 after C=104 -> status Z=1 (001), C stays 104.
- A=0x7FFF, B=1, ADD -> C=0x8000, status=110 (V=1, N=1). Then asel=0, B=0x8000, ASR, shamt=15, ADD -> C=0xFFFF, V=0.
- Three ops back-to-back with out_ready=0 -> in_ready falls after 2 accepted. Raising out_ready yields 3 completions in order with correct C values.
- rst_n low one cycle after an accept -> out_valid=0, C=0, status=0 immediately, no later completion. The next op after release completes normally.
